// File: rtl/cond_logic_unit.sv
// Conditional-execution and NZCV flag-commit stage for a single-cycle ARM-style core.
// Gates state-changing writes on the condition field and sequences multi-cycle MUL/DIV commits.
module cond_logic_unit #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       instr_valid,
   input  logic [3:0] cond,
   input  logic [3:0] alu_control,
   input  logic [1:0] flag_w,
   input  logic [3:0] alu_flags,
   input  logic       pc_s,
   input  logic       reg_w,
   input  logic       mem_w,
   input  logic       no_write,
   output logic       pc_src,
   output logic       reg_write,
   output logic       mem_write,
   output logic       stall,
   output logic [3:0] flags,
   output logic       cond_ex
);

   localparam logic [3:0] ALU_MUL  = 4'b1010;
   localparam logic [3:0] ALU_DIV  = 4'b1011;
   localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 2);
   localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_BUSY   = 2'b01,
      ST_COMMIT = 2'b10
   } state_t;

   typedef struct packed {
      logic       cond_ex;
      logic [1:0] flag_w;
      logic       pc_s;
      logic       reg_w;
      logic       mem_w;
      logic       no_write;
   } ctl_t;

   // flag vector layout is {N,Z,C,V}
   function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
      logic res;
      case (c)
         4'b0000: res = f[2];
         4'b0001: res = ~f[2];
         4'b0010: res = f[1];
         4'b0011: res = ~f[1];
         4'b0100: res = f[3];
         4'b0101: res = ~f[3];
         4'b0110: res = f[0];
         4'b0111: res = ~f[0];
         4'b1000: res = f[1] & ~f[2];
         4'b1001: res = ~f[1] | f[2];
         4'b1010: res = ~(f[3] ^ f[0]);
         4'b1011: res = f[3] ^ f[0];
         4'b1100: res = ~f[2] & ~(f[3] ^ f[0]);
         4'b1101: res = f[2] | (f[3] ^ f[0]);
         4'b1110: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] merge_flags(input logic [3:0] old_f, input logic [3:0] new_f,
                                              input logic [1:0] fw);
      logic [3:0] res;
      res[3:2] = fw[1] ? new_f[3:2] : old_f[3:2];
      res[1:0] = fw[0] ? new_f[1:0] : old_f[1:0];
      return res;
   endfunction

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] flags_q, flags_d;
   ctl_t       ctl_q, ctl_d;

   logic cond_pass_s, is_multi_s, ex_s;
   logic pc_src_s, reg_write_s, mem_write_s, stall_s;

   // Next-state, flag-commit and gated-write decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      flags_d     = flags_q;
      ctl_d       = ctl_q;
      ex_s        = 1'b0;
      pc_src_s    = 1'b0;
      reg_write_s = 1'b0;
      mem_write_s = 1'b0;
      stall_s     = 1'b0;
      cond_pass_s = cond_check(cond, flags_q);
      is_multi_s  = (alu_control == ALU_MUL) || (alu_control == ALU_DIV);
      case (state_q)
         ST_IDLE: begin
            ex_s = cond_pass_s & instr_valid;
            if (instr_valid && is_multi_s) begin
               stall_s = 1'b1;
               ctl_d   = '{cond_ex: ex_s, flag_w: flag_w, pc_s: pc_s, reg_w: reg_w,
                           mem_w: mem_w, no_write: no_write};
               cnt_d   = (alu_control == ALU_MUL) ? MUL_LOAD : DIV_LOAD;
               state_d = (cnt_d == 4'd0) ? ST_COMMIT : ST_BUSY;
            end else begin
               pc_src_s    = pc_s & ex_s;
               reg_write_s = reg_w & ex_s & ~no_write;
               mem_write_s = mem_w & ex_s;
               if (ex_s) begin
                  flags_d = merge_flags(flags_q, alu_flags, flag_w);
               end else begin
                  flags_d = flags_q;
               end
            end
         end
         ST_BUSY: begin
            ex_s    = ctl_q.cond_ex;
            stall_s = 1'b1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_COMMIT;
            end else begin
               cnt_d   = cnt_q - 4'd1;
            end
         end
         ST_COMMIT: begin
            ex_s        = ctl_q.cond_ex;
            pc_src_s    = ctl_q.pc_s & ctl_q.cond_ex;
            reg_write_s = ctl_q.reg_w & ctl_q.cond_ex & ~ctl_q.no_write;
            mem_write_s = ctl_q.mem_w & ctl_q.cond_ex;
            if (ctl_q.cond_ex) begin
               flags_d = merge_flags(flags_q, alu_flags, ctl_q.flag_w);
            end else begin
               flags_d = flags_q;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // State, counter, NZCV and latched-control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         flags_q <= 4'b0000;
         ctl_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flags_q <= flags_d;
         ctl_q   <= ctl_d;
      end
   end

   // Outputs drop to their reset values the moment rst_n falls, even mid-operation
   assign pc_src    = pc_src_s & rst_n;
   assign reg_write = reg_write_s & rst_n;
   assign mem_write = mem_write_s & rst_n;
   assign stall     = stall_s & rst_n;
   assign cond_ex   = ex_s & rst_n;
   assign flags     = flags_q;

endmodule

// File: tb/tb_cond_logic_unit.sv
// Scoreboard bench for cond_logic_unit: a cycle-level reference model queues expected outputs
// and a negedge monitor compares them against the DUT.
module tb_cond_logic_unit;

   localparam int MULT_N = 4;
   localparam int DIV_N  = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic [3:0] cond = 4'd0;
   logic [3:0] alu_control = 4'd0;
   logic [1:0] flag_w = 2'd0;
   logic [3:0] alu_flags = 4'd0;
   logic       pc_s = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0;
   logic       pc_src, reg_write, mem_write, stall, cond_ex;
   logic [3:0] flags;

   cond_logic_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .cond(cond),
      .alu_control(alu_control), .flag_w(flag_w), .alu_flags(alu_flags),
      .pc_s(pc_s), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
      .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
      .stall(stall), .flags(flags), .cond_ex(cond_ex)
   );

   always #5 clk = ~clk;

   // expected word: {cond_ex, pc_src, reg_write, mem_write, stall, flags[3:0]}
   logic [8:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   // reference model state
   logic [3:0] m_flags = 4'd0;
   int         m_left = 0;
   logic       s_ce, s_p, s_r, s_m, s_nw;
   logic [1:0] s_fw;

   function automatic bit holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] upd(input logic [3:0] f, input logic [3:0] a, input logic [1:0] fw);
      logic [3:0] r;
      r = f;
      if (fw[1]) begin r[3] = a[3]; r[2] = a[2]; end
      if (fw[0]) begin r[1] = a[1]; r[0] = a[0]; end
      return r;
   endfunction

   task automatic step(input logic rst_in, input logic v, input logic [3:0] c, input logic [3:0] alu,
                       input logic [1:0] fw, input logic [3:0] af, input logic p, input logic r,
                       input logic m, input logic nw);
      logic [8:0] e;
      bit ce;
      @(posedge clk);
      #1;
      rst_n = rst_in; instr_valid = v; cond = c; alu_control = alu; flag_w = fw;
      alu_flags = af; pc_s = p; reg_w = r; mem_w = m; no_write = nw;
      if (!rst_in) begin
         e = 9'd0;
         m_flags = 4'd0;
         m_left = 0;
      end else if (m_left == 1) begin
         e = {s_ce, s_p & s_ce, s_r & s_ce & !s_nw, s_m & s_ce, 1'b0, m_flags};
         if (s_ce) m_flags = upd(m_flags, af, s_fw);
         m_left = 0;
      end else if (m_left > 1) begin
         e = {s_ce, 3'b000, 1'b1, m_flags};
         m_left = m_left - 1;
      end else begin
         ce = v && holds(c, m_flags);
         if (v && (alu == 4'b1010 || alu == 4'b1011)) begin
            e = {ce, 3'b000, 1'b1, m_flags};
            s_ce = ce; s_p = p; s_r = r; s_m = m; s_nw = nw; s_fw = fw;
            m_left = ((alu == 4'b1010) ? MULT_N : DIV_N) - 1;
         end else begin
            e = {ce, p & ce, r & ce & !nw, m & ce, 1'b0, m_flags};
            if (ce) m_flags = upd(m_flags, af, fw);
         end
      end
      exp_q.push_back(e);
   endtask

   // Monitor: pops one expectation per cycle, sampled away from the active edge
   initial begin
      logic [8:0] got, want;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = {cond_ex, pc_src, reg_write, mem_write, stall, flags};
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("FAIL vec%0d {cond_ex,pc_src,reg_write,mem_write,stall,flags}: got %b required %b",
                        vectors, got, want);
            end
         end
      end
   end

   initial begin
      // reset, then ADDS sets Z
      step(0, 0, 4'he, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0);
      step(0, 1, 4'he, 4'h0, 2'b11, 4'hf, 1, 1, 1, 0);
      step(1, 1, 4'he, 4'h0, 2'b11, 4'b0100, 0, 1, 0, 0);
      // EQ passes, NE fails
      step(1, 1, 4'h0, 4'h0, 2'b00, 4'h0, 0, 1, 0, 0);
      step(1, 1, 4'h1, 4'h0, 2'b11, 4'hf, 1, 1, 1, 0);
      // ANDS keeps C,V; CMP suppresses reg_write only
      step(1, 1, 4'he, 4'h0, 2'b10, 4'b1011, 0, 1, 0, 0);
      step(1, 1, 4'he, 4'h2, 2'b11, 4'b0011, 0, 1, 0, 1);
      // MUL, four cycles with varying alu_flags
      for (int i = 0; i < MULT_N; i++)
         step(1, 1, 4'he, 4'b1010, 2'b11, 4'(i + 4), 0, 1, 0, 0);
      step(1, 0, 4'he, 4'h0, 2'b11, 4'hf, 1, 1, 1, 0);
      // MUL back-to-back right after COMMIT
      for (int i = 0; i < 2 * MULT_N; i++)
         step(1, 1, 4'hb, 4'b1010, 2'b01, 4'(9 * i), 1, 1, 1, 0);
      // DIV never-condition
      for (int i = 0; i < DIV_N; i++)
         step(1, 1, 4'hf, 4'b1011, 2'b11, 4'hf, 1, 1, 1, 0);
      // DIV abandoned by reset in its fourth cycle
      for (int i = 0; i < 3; i++)
         step(1, 1, 4'he, 4'b1011, 2'b11, 4'hf, 1, 1, 1, 0);
      step(0, 1, 4'he, 4'b1011, 2'b11, 4'hf, 1, 1, 1, 0);
      step(0, 1, 4'he, 4'b1011, 2'b11, 4'hf, 1, 1, 1, 0);
      step(1, 1, 4'he, 4'h0, 2'b11, 4'b1001, 1, 1, 1, 0);
      step(1, 1, 4'hb, 4'h0, 2'b00, 4'h0, 1, 1, 1, 0);
      // randomized traffic, including random resets and ignored inputs while busy
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] alu;
         alu = ($urandom_range(0, 99) < 15) ? {3'b101, 1'($urandom_range(0, 1))} : 4'($urandom);
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0), 4'($urandom), alu,
              2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
